shift_reg_univ: RTL
===================

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter RST_VAL, default {WIDTH{1'b0}}, value loaded into Q on reset and on sync clear.
REQ-003 Local constant CW = $clog2(WIDTH), shift-counter width.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  operation enable; when 0 all state holds.
REQ-007 mode  input  3  operation select, sampled on rising clk when en=1.
REQ-008 data  input  WIDTH  parallel load value.
REQ-009 sin_l  input  1  serial input entering at MSB during shift right.
REQ-010 sin_r  input  1  serial input entering at LSB during shift left.
REQ-011 Q  output  WIDTH  register contents.
REQ-012 QB  output  WIDTH  bitwise complement of Q.
REQ-013 sout_l  output  1  Q[WIDTH-1].
REQ-014 sout_r  output  1  Q[0].
REQ-015 cnt  output  CW  shift/rotate operation count, modulo WIDTH.
REQ-016 cnt_wrap  output  1  one-cycle pulse on counter wrap.

Function
REQ-017 Q, cnt and cnt_wrap shall be registered; QB, sout_l, sout_r shall be combinational from Q, with QB == ~Q at all times, including during reset.
REQ-018 With en=1, the mode at the rising edge shall select: 000 hold; 001 shift left Q<={Q[W-2:0],sin_r}; 010 shift right Q<={sin_l,Q[W-1:1]}; 011 rotate left Q<={Q[W-2:0],Q[W-1]}; 100 rotate right Q<={Q[0],Q[W-1:1]}; 101 load Q<=data; 110 sync clear Q<=RST_VAL; 111 invert Q<=~Q.
REQ-019 Latency: the new Q value shall be visible one clock after the sampling edge; no combinational path from data, sin_l or sin_r to Q.
REQ-020 Modes 001-100 with en=1 shall increment cnt by 1; at cnt==WIDTH-1 cnt shall wrap to 0 and cnt_wrap shall be 1 for exactly the following cycle.
REQ-021 WIDTH not a power of two: cnt shall still wrap at WIDTH-1, never reaching WIDTH.
REQ-022 Modes 101 and 110 with en=1 shall force cnt to 0 and cnt_wrap to 0; this takes precedence over any wrap in progress.
REQ-023 Modes 000 and 111, or en=0, shall hold cnt; cnt_wrap shall be 0 in every cycle not following a wrap.
REQ-024 Changes on mode, data or serial inputs while en=0 shall have no effect on any output.
REQ-025 Shift-then-rotate sequences shall share one counter; no per-mode counting.

Reset
REQ-026 rst=1 shall immediately, without waiting for a clock edge, set Q=RST_VAL, cnt=0, cnt_wrap=0, and consequently QB=~RST_VAL.
REQ-027 While rst=1, all inputs shall be ignored, including en=1 and clock edges.
REQ-028 Deassertion of rst shall take effect on the first rising edge with rst=0; an operation sampled at that edge shall execute normally.
REQ-029 Reset asserted mid-operation, e.g. cnt=5 during a shift run, shall abort it; after release cnt restarts at 0 with no spurious cnt_wrap.

Verification
REQ-030 Async reset: WIDTH=8, rst pulsed high between clock edges -> Q=8'h00, QB=8'hFF, cnt=0 before the next edge.
REQ-031 Load/invert: en=1, mode=101, data=8'hA5 -> Q=8'hA5, QB=8'h5A; next mode=111 -> Q=8'h5A; cnt stays 0.
REQ-032 Shift left: Q=8'h81, mode=001, sin_r=1 -> Q=8'h03, sout_l=0, cnt=1; then mode=010, sin_l=0 -> Q=8'h01, cnt=2.
REQ-033 Rotate wrap: Q=8'h01, mode=011 for 8 cycles -> Q=8'h01 again, cnt returns to 0, cnt_wrap high for exactly one cycle after the 8th edge.
REQ-034 Enable gating: Q=8'h3C, en=0, mode=101, data=8'hFF toggled for 4 cycles -> Q stays 8'h3C, cnt unchanged.
REQ-035 Reset mid-run plus odd width: WIDTH=5, cnt=3, rst pulse -> cnt=0, Q=RST_VAL; then 5 rotates -> cnt_wrap once, cnt never exceeds 4.

Source files
------------

// File: rtl/shift_reg_univ_if.sv
// Bus bundle for the universal shift register: control/data in, register state out.
interface shift_reg_univ_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] data;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] QB;
    logic             sout_l;
    logic             sout_r;
    logic [CW-1:0]    cnt;
    logic             cnt_wrap;

    modport master (
        output en, mode, data, sin_l, sin_r,
        input  Q, QB, sout_l, sout_r, cnt, cnt_wrap
    );

    modport slave (
        input  en, mode, data, sin_l, sin_r,
        output Q, QB, sout_l, sout_r, cnt, cnt_wrap
    );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift / rotate / load / clear / invert,
// with a shared modulo-WIDTH count of shift and rotate operations.
module shift_reg_univ #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    shift_reg_univ_if.slave bus
);
    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHL  = 3'b001,
        M_SHR  = 3'b010,
        M_ROL  = 3'b011,
        M_ROR  = 3'b100,
        M_LOAD = 3'b101,
        M_CLR  = 3'b110,
        M_INV  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_wrap_nxt;
    logic             w_count;

    // Next-state select; the wrap flag defaults low so it only ever lasts one cycle.
    always_comb begin
        w_q_nxt    = r_q;
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        w_count    = 1'b0;
        if (bus.en) begin
            case (mode_e'(bus.mode))
                M_HOLD: w_q_nxt = r_q;
                M_SHL: begin
                    w_q_nxt = {r_q[WIDTH-2:0], bus.sin_r};
                    w_count = 1'b1;
                end
                M_SHR: begin
                    w_q_nxt = {bus.sin_l, r_q[WIDTH-1:1]};
                    w_count = 1'b1;
                end
                M_ROL: begin
                    w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_count = 1'b1;
                end
                M_ROR: begin
                    w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
                    w_count = 1'b1;
                end
                M_LOAD: begin
                    w_q_nxt   = bus.data;
                    w_cnt_nxt = '0;
                end
                M_CLR: begin
                    w_q_nxt   = RST_VAL;
                    w_cnt_nxt = '0;
                end
                M_INV: w_q_nxt = ~r_q;
                default: w_q_nxt = r_q;
            endcase
            // Compare against WIDTH-1 explicitly so non-power-of-two widths wrap correctly.
            if (w_count) begin
                if (r_cnt == CNT_MAX) begin
                    w_cnt_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
        end
    end

    // State register with immediate reset to the configured value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= RST_VAL;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_cnt  <= w_cnt_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bus.Q        = r_q;
    assign bus.QB       = ~r_q;
    assign bus.sout_l   = r_q[WIDTH-1];
    assign bus.sout_r   = r_q[0];
    assign bus.cnt      = r_cnt;
    assign bus.cnt_wrap = r_wrap;
endmodule
